// File: rtl/plus_raster_irq.sv
// Programmable raster interrupt generator for Plus/GX4000 mode.
//
// Counts scanlines from the CRTC sync pair and raises pri_irq when the line
// about to begin equals the PRI line register. It also supplies an IM2 vector
// for the interrupt acknowledge cycle.
//
// Ports:
//   clk, reset_n       system clock, asynchronous active-low reset
//   cclk_en            CRTC character-clock enable; sync edges are sampled only when high
//   hsync_i, vsync_i   CRTC sync outputs
//   plus_en            Plus mode with the ASIC unlocked; low holds the irq logic idle
//   reg_wr, reg_addr,  ASIC register write strobe, address (0 PRI line, 1 status, 2 IVR)
//   reg_din, reg_dout  and data; reg_dout is combinational from reg_addr
//   iack               M1 & IORQ level from the CPU bus
//   pri_mode           high when a raster line is programmed; masks the GA 52-line irq
//   pri_irq            registered active-high interrupt request
//   vector             IM2 vector {ivr[7:3], VEC_LOW}
module plus_raster_irq #(
  parameter logic [2:0]  VEC_LOW = 3'b110,
  parameter int unsigned LINE_W  = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cclk_en,
  input  logic       hsync_i,
  input  logic       vsync_i,
  input  logic       plus_en,
  input  logic       reg_wr,
  input  logic [1:0] reg_addr,
  input  logic [7:0] reg_din,
  output logic [7:0] reg_dout,
  input  logic       iack,
  output logic       pri_mode,
  output logic       pri_irq,
  output logic [7:0] vector
);

  localparam logic [LINE_W-1:0] LineMax = {LINE_W{1'b1}};
  localparam logic [LINE_W:0]   WideOne = {{LINE_W{1'b0}}, 1'b1};

  logic              hs_prev_q, hs_prev_d;
  logic              vs_prev_q, vs_prev_d;
  logic              iack_prev_q, iack_prev_d;
  logic [LINE_W-1:0] line_cnt_q, line_cnt_d;
  logic [LINE_W-1:0] pri_line_q, pri_line_d;
  logic [7:0]        ivr_q, ivr_d;
  logic              pending_q, pending_d;
  logic              pri_irq_q, pri_irq_d;

  logic              hs_rise, vs_rise, iack_rise;
  logic [LINE_W:0]   line_inc;
  logic              match, status_clr, ack_clr;

  always_comb begin
    hs_rise   = cclk_en & hsync_i & ~hs_prev_q;
    vs_rise   = cclk_en & vsync_i & ~vs_prev_q;
    iack_rise = iack & ~iack_prev_q;

    // One bit wider so a saturated counter can never alias back onto a PRI value.
    line_inc  = {1'b0, line_cnt_q} + WideOne;

    // Compare against the line that this hsync starts; a coincident vsync wins.
    match = hs_rise & ~vs_rise & plus_en & (pri_line_q != '0) &
            (line_inc == {1'b0, pri_line_q});

    status_clr = reg_wr & (reg_addr == 2'd1) & reg_din[7];
    // ivr[0] selects manual clear: iack then leaves pending alone.
    ack_clr    = iack_rise & pending_q & ~ivr_q[0];
  end

  always_comb begin
    hs_prev_d   = cclk_en ? hsync_i : hs_prev_q;
    vs_prev_d   = cclk_en ? vsync_i : vs_prev_q;
    iack_prev_d = iack;

    line_cnt_d = line_cnt_q;
    if (vs_rise) begin
      line_cnt_d = '0;
    end else if (hs_rise && (line_cnt_q != LineMax)) begin
      line_cnt_d = line_inc[LINE_W-1:0];
    end

    // Set has priority over any clear; plus_en low forces idle.
    pending_d = pending_q;
    if (!plus_en) begin
      pending_d = 1'b0;
    end else if (match) begin
      pending_d = 1'b1;
    end else if (status_clr || ack_clr) begin
      pending_d = 1'b0;
    end

    pri_irq_d = pending_d & plus_en;

    pri_line_d = pri_line_q;
    ivr_d      = ivr_q;
    if (reg_wr) begin
      if (reg_addr == 2'd0) pri_line_d = reg_din[LINE_W-1:0];
      if (reg_addr == 2'd2) ivr_d      = reg_din;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hs_prev_q   <= 1'b0;
      vs_prev_q   <= 1'b0;
      iack_prev_q <= 1'b0;
      line_cnt_q  <= '0;
      pri_line_q  <= '0;
      ivr_q       <= 8'h00;
      pending_q   <= 1'b0;
      pri_irq_q   <= 1'b0;
    end else begin
      hs_prev_q   <= hs_prev_d;
      vs_prev_q   <= vs_prev_d;
      iack_prev_q <= iack_prev_d;
      line_cnt_q  <= line_cnt_d;
      pri_line_q  <= pri_line_d;
      ivr_q       <= ivr_d;
      pending_q   <= pending_d;
      pri_irq_q   <= pri_irq_d;
    end
  end

  always_comb begin
    pri_mode = plus_en & (pri_line_q != '0);
    pri_irq  = pri_irq_q;
    vector   = {ivr_q[7:3], VEC_LOW};

    reg_dout = 8'hFF;
    unique case (reg_addr)
      2'd0: reg_dout = 8'(pri_line_q);
      2'd1: reg_dout = {pending_q, 6'b0, pri_mode};
      2'd2: reg_dout = ivr_q;
      2'd3: reg_dout = 8'hFF;
    endcase
  end

endmodule

// File: doc/plus_raster_irq.md
Name: plus_raster_irq

Overview:
Programmable Raster Interrupt (PRI) generator for Plus/GX4000 mode. It sits between the CRTC sync outputs and the Z80 interrupt input.
- Counts scanlines from the CRTC HSYNC/VSYNC pair.
- Raises pri_irq when the count matches the ASIC PRI register.
- Supplies the IM2 vector during interrupt acknowledge.
- Its pri_irq output is combined into the CPU int_n term on the motherboard.

Parameters:
VEC_LOW, 3'b110, low three bits of the IM2 vector for a raster source.
LINE_W, 8, scanline counter / PRI compare width.

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
cclk_en  in  1  CRTC character-clock enable; sync edges are evaluated only when high
hsync_i  in  1  CRTC HSYNC
vsync_i  in  1  CRTC VSYNC
plus_en  in  1  Plus mode and ASIC unlocked; 0 forces block idle
reg_wr  in  1  one-clk ASIC register write strobe
reg_addr  in  2  0=PRI line, 1=status, 2=IVR
reg_din  in  8  write data
reg_dout  out  8  read data (combinational from reg_addr)
iack  in  1  M1 & IORQ level from the CPU bus
pri_mode  out  1  1 when PRI line != 0; motherboard masks the GA 52-line interrupt
pri_irq  out  1  active-high interrupt request
vector  out  8  IM2 vector, {ivr[7:3], VEC_LOW}

Behaviour:
Reset (async, reset_n=0):
- pri_line=0, ivr=0, line_cnt=0, pending=0.
- hs_d=0, vs_d=0, iack_d=0.
- pri_irq=0, pri_mode=0, vector={5'b0,VEC_LOW}, reg_dout=PRI line (0).

Edge detection:
- On cycles with cclk_en=1: hs_d<=hsync_i, vs_d<=vsync_i.
- hs_rise = cclk_en & hsync_i & ~hs_d; vs_rise is defined the same way.

Line counter (LINE_W bits):
- vs_rise sets it to 0.
- Otherwise hs_rise increments it, saturating at 255; no wrap.
- If vs_rise and hs_rise occur together, the counter clears and the cycle is not a match.

Match:
- On hs_rise with plus_en=1, pri_line!=0 and (line_cnt+1)==pri_line, set pending on the next clk edge.
- The compare uses the pre-write pri_line if a write lands in the same cycle.
- pri_line==0 never matches.

pri_irq and pri_mode:
- pri_irq = pending & plus_en, registered, with one cycle of latency from the hs_rise cycle.
- pri_mode = (pri_line!=0) & plus_en.

Acknowledge:
- iack_rise = iack & ~iack_d, sampled every clk.
- On iack_rise with pending=1 and ivr[0]=0: clear pending (auto-clear).
- If ivr[0]=1, pending persists until software writes status bit7=1.

Simultaneous events:
- Set and clear in the same cycle: set wins.
- Status write and iack together: the clear is applied once and pending goes to 0 unless a match occurs in that cycle.

Registers:
- addr0: R/W pri_line.
- addr1 read: {pending, 6'b0, pri_mode}. addr1 write: bit7=1 clears pending; other bits are ignored.
- addr2 R/W: ivr, with bits 2:1 stored but unused.
- addr3 reads 8'hFF; writes are ignored.

plus_en=0:
- Counter keeps running; pending and pri_irq are forced to 0 and no new pending is set.
- Registers remain writable.

Mid-frame reset:
- Everything returns to reset values.
- The first hs_rise after release counts as line 1.

Test Plan:
- PRI basic: pri_line=3, ivr=8'h40, plus_en=1; one vsync pulse then 3 hsync pulses (cclk_en every 16 clk) -> pri_irq rises exactly 1 clk after the 3rd hs_rise; vector=8'h46; none after the 1st/2nd.
- Auto-clear ack: from the asserted state, assert iack for 4 clk -> pri_irq drops 1 clk after the iack rising edge; holding iack does not re-trigger; next match at the following frame's line 3.
- Manual clear: ivr=8'h41, match -> iack does not clear; status read=8'h81; write status 8'h80 -> pri_irq=0, status=8'h01.
- Saturation/zero: pri_line=0 -> pri_mode=0, no irq over 300 lines; pri_line=255, 300 hsyncs with no vsync -> exactly one irq at line 255; counter holds at 255.
- Simultaneous: match on the same clk as a status-clear write -> pending stays 1. vs_rise and hs_rise in the same cclk_en cycle -> counter=0, no match. Writing pri_line=5 on the clk of a line-4 hs_rise with old pri_line=4 -> irq fires.
- Reset/disable: drop reset_n mid-frame with pending=1 -> pri_irq=0 immediately (async), all registers 0. With plus_en=0, matches give no irq while the counter still advances (verified by enabling plus_en mid-frame).
